traffic_light_ctrl_n: RTL
=========================

# traffic_light_ctrl_n

Parametrised N-phase traffic light controller, successor to the two-direction `TrafficLights` block. Cycles green → yellow → all-red through `NUM_PHASES` signal groups. Skips phases with no demand and supports a flashing-yellow night mode. Timing advances only on `ce` ticks, which the upstream tick/counter logic supplies; `lights` and `time_left` feed the lamp drivers and countdown displays.

## Interface
Parameters:
- `NUM_PHASES`, 2: number of signal groups (≥2).
- `TIME_W`, 8: width of the green-time input and countdown.
- `YELLOW_TIME`, 3: yellow duration in ticks (≥1).
- `ALL_RED_TIME`, 1: all-red clearance in ticks (≥1).

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ce` in 1: time tick; one-cycle pulse equals one time unit.
- `green_time` in `TIME_W`: green duration in ticks, sampled on GREEN entry.
- `demand` in `NUM_PHASES`: per-phase request (detector or pedestrian), level-sensitive.
- `flash` in 1: night mode request.
- `lights` out `3*NUM_PHASES`: per phase i, bits [3i+2:3i] = {green, yellow, red}.
- `phase` out `PH_W`: current phase index. `PH_W = max(1, $clog2(NUM_PHASES))`.
- `time_left` out `TIME_W`: ticks remaining in the current interval after the present one.
- `cycle_start` out 1: one-clk pulse when phase 0 enters GREEN.

## Operation
- States: ALL_RED, GREEN, YELLOW, FLASH.
- Entering any timed state with duration D loads `cnt = D-1`.
- On each `ce` cycle: if `cnt==0` take the transition, else decrement `cnt`. A state therefore lasts exactly D ticks.
- GREEN duration D = `green_time`, with 0 clamped to 1. The value is sampled once on entry; later changes do not affect the running green.
- GREEN → YELLOW → ALL_RED, with `phase` unchanged.
- ALL_RED → GREEN of the next phase. Search round-robin from `phase+1` (wrapping) for the first i with `demand[i]=1`; the current phase is the last candidate.
- If `demand==0`, advance to `phase+1` mod NUM_PHASES (fixed-time fallback).
- Lamps:
  - GREEN/YELLOW: active phase shows G/Y; all others red.
  - ALL_RED: all red.
  - FLASH: all phases yellow when `flash_on=1`, all lamps dark when 0.
- `flash=1`, in any state and independent of `ce`, enters FLASH on the next clk with `flash_on=1`.
- In FLASH, `flash_on` toggles on every `ce`, and `time_left=0`.
- Deasserting `flash` enters ALL_RED with `ALL_RED_TIME`; `phase` is retained.
- `ce=0` freezes `cnt`, state and `flash_on`. `rst` and `flash` entry are still honoured.
- `rst` has priority over everything. Reset values:
  - state ALL_RED, `cnt=ALL_RED_TIME-1`, `phase=NUM_PHASES-1`, `flash_on=0`.
  - `lights` all red (bit 3i set for every i), `time_left=ALL_RED_TIME-1`, `cycle_start=0`.
  - Consequence: phase 0 is the first green when demand is absent.
- Arithmetic: `cnt` is `TIME_W` bits. `YELLOW_TIME-1` and `ALL_RED_TIME-1` must fit in `TIME_W`; this is an elaboration-time check.

## Timing
- Outputs are a Moore decode of registered state: `lights`, `phase` and `time_left` change in the cycle after the transitioning `ce` edge.
- No combinational path from `demand`/`green_time` to outputs.
- `cycle_start` is registered and aligned with the first cycle phase 0 shows green.
- Simultaneous events:
  - `flash` and a timer expiry: FLASH wins.
  - Phase selection uses `demand` sampled on the ALL_RED expiry cycle only.
- Reset mid-interval: outputs show reset values on the cycle after `rst` is sampled high.
- Normal timing resumes from the all-red start on the first `ce` after release.

## Structure
- Package `traffic_pkg`:
  - state enum `tl_state_t`.
  - lamp bit offsets `LAMP_R=0`, `LAMP_Y=1`, `LAMP_G=2`.
  - function `next_phase(cur, demand)`: round-robin priority search.
- Sub-module `phase_timer`: loadable down-counter with `ce` and a `zero` flag, `TIME_W` parameter.
- FSM, phase selection and lamp decode live in the top level.

## Test plan
Defaults N=2, TIME_W=8, YELLOW=3, ALL_RED=1, `green_time=15`, `ce` every cycle unless stated.
- Reset held 3 cycles → `lights=6'b001001`, `phase=1`, `time_left=0`, `cycle_start=0`. Re-assert `rst` mid-green → same values next cycle.
- `demand=0` → phase 0 green 15 ticks (`time_left` 14..0), yellow 3, all-red 1, then phase 1 green. `cycle_start` pulses every 38 ticks.
- N=3, `demand=3'b100` throughout → only phase 2 ever greens; phases 0/1 stay red. Sequence is ALL_RED→GREEN(2)→YELLOW→ALL_RED→GREEN(2).
- `green_time=0` → green lasts exactly 1 tick. Changing `green_time` 15→5 mid-green leaves the current green at 15; the next green is 5.
- `flash` asserted mid-green with `ce` low → FLASH next clk, `lights=6'b010010`. Toggles to `6'b000000` on the next `ce`. Release → all red for 1 tick, then green of the next phase.
- `ce` every 4th cycle → all durations scale ×4 in clk cycles. Outputs hold between ticks.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types, lamp bit offsets and the round-robin phase search for the
// N-phase traffic light controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_FLASH   = 2'd3
    } tl_state_t;

    localparam int LAMP_R = 0;
    localparam int LAMP_Y = 1;
    localparam int LAMP_G = 2;

    // Largest phase count the search function can handle.
    localparam int MAX_PHASES = 32;
    localparam int MAX_IDX_W  = 5;

    // First requesting phase after cur (wrapping), cur itself last;
    // with no demand at all, simply cur+1 mod n.
    function automatic int next_phase(input int cur,
                                      input logic [MAX_PHASES-1:0] demand,
                                      input int n);
        int   idx;
        int   result;
        logic found;
        logic [MAX_IDX_W-1:0] bit_sel;
        result = (cur + 1 >= n) ? 0 : cur + 1;
        found  = 1'b0;
        for (int k = 1; k <= MAX_PHASES; k++) begin
            if (k <= n) begin
                idx = cur + k;
                if (idx >= n) idx = idx - n;
                bit_sel = idx[MAX_IDX_W-1:0];
                if (!found && demand[bit_sel]) begin
                    result = idx;
                    found  = 1'b1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_n_phase_timer.sv
// Loadable down-counter that advances only on ce and saturates at zero.
module phase_timer #(
    parameter int TIME_W = 8
) (
    input  logic              clk,
    input  logic              i_load,
    input  logic [TIME_W-1:0] i_load_val,
    input  logic              i_ce,
    output logic [TIME_W-1:0] o_cnt,
    output logic              o_zero
);

    logic [TIME_W-1:0] r_cnt;

    // A load (also used for reset) takes priority over counting.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_ce && (r_cnt != '0)) begin
            r_cnt <= r_cnt - TIME_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// N-phase traffic light controller: green -> yellow -> all-red per phase,
// demand-driven phase skipping and a flashing-yellow night mode.
module traffic_light_ctrl_n
    import traffic_pkg::*;
#(
    parameter  int NUM_PHASES   = 2,
    parameter  int TIME_W       = 8,
    parameter  int YELLOW_TIME  = 3,
    parameter  int ALL_RED_TIME = 1,
    localparam int PH_W = ($clog2(NUM_PHASES) > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic [TIME_W-1:0]       green_time,
    input  logic [NUM_PHASES-1:0]   demand,
    input  logic                    flash,
    output logic [3*NUM_PHASES-1:0] lights,
    output logic [PH_W-1:0]         phase,
    output logic [TIME_W-1:0]       time_left,
    output logic                    cycle_start
);

    if (NUM_PHASES < 2 || NUM_PHASES > MAX_PHASES) begin : g_bad_phases
        $error("NUM_PHASES out of range");
    end
    if (YELLOW_TIME < 1 || (YELLOW_TIME - 1) >= (1 << TIME_W)) begin : g_bad_yellow
        $error("YELLOW_TIME-1 must fit in TIME_W bits");
    end
    if (ALL_RED_TIME < 1 || (ALL_RED_TIME - 1) >= (1 << TIME_W)) begin : g_bad_all_red
        $error("ALL_RED_TIME-1 must fit in TIME_W bits");
    end

    localparam logic [TIME_W-1:0] YEL_LOAD = TIME_W'(YELLOW_TIME - 1);
    localparam logic [TIME_W-1:0] AR_LOAD  = TIME_W'(ALL_RED_TIME - 1);

    tl_state_t               r_state;
    tl_state_t               w_state_nxt;
    logic [PH_W-1:0]         r_phase;
    logic [PH_W-1:0]         w_phase_nxt;
    logic [PH_W-1:0]         w_sel_phase;
    logic                    r_flash_on;
    logic                    w_flash_on_nxt;
    logic                    r_cycle_start;
    logic                    w_cs_nxt;
    logic                    w_load;
    logic [TIME_W-1:0]       w_load_val;
    logic [TIME_W-1:0]       w_green_load;
    logic [TIME_W-1:0]       w_cnt;
    logic                    w_zero;
    logic [MAX_PHASES-1:0]   w_dem_ext;
    logic [3*NUM_PHASES-1:0] w_lights;

    phase_timer #(
        .TIME_W (TIME_W)
    ) u_timer (
        .clk        (clk),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_ce       (ce),
        .o_cnt      (w_cnt),
        .o_zero     (w_zero)
    );

    // A zero green time still gives one tick of green.
    assign w_green_load = (green_time == '0) ? '0 : green_time - TIME_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_ALL_RED;
            r_phase       <= PH_W'(NUM_PHASES - 1);
            r_flash_on    <= 1'b0;
            r_cycle_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_flash_on    <= w_flash_on_nxt;
            r_cycle_start <= w_cs_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_flash_on_nxt = r_flash_on;
        w_cs_nxt       = 1'b0;
        w_load         = 1'b0;
        w_load_val     = AR_LOAD;
        w_dem_ext      = '0;
        w_dem_ext[NUM_PHASES-1:0] = demand;
        w_sel_phase    = PH_W'(next_phase(int'(r_phase), w_dem_ext, NUM_PHASES));

        // Night mode is checked before the timer so it wins over an expiry.
        if (flash) begin
            if (r_state != ST_FLASH) begin
                w_state_nxt    = ST_FLASH;
                w_flash_on_nxt = 1'b1;
            end else if (ce) begin
                w_flash_on_nxt = !r_flash_on;
            end
        end else if (r_state == ST_FLASH) begin
            w_state_nxt    = ST_ALL_RED;
            w_flash_on_nxt = 1'b0;
            w_load         = 1'b1;
            w_load_val     = AR_LOAD;
        end else if (ce && w_zero) begin
            w_load = 1'b1;
            case (r_state)
                ST_GREEN: begin
                    w_state_nxt = ST_YELLOW;
                    w_load_val  = YEL_LOAD;
                end
                ST_YELLOW: begin
                    w_state_nxt = ST_ALL_RED;
                    w_load_val  = AR_LOAD;
                end
                default: begin
                    w_state_nxt = ST_GREEN;
                    w_phase_nxt = w_sel_phase;
                    w_load_val  = w_green_load;
                    w_cs_nxt    = (w_sel_phase == '0);
                end
            endcase
        end

        if (rst) begin
            w_load     = 1'b1;
            w_load_val = AR_LOAD;
        end
    end

    // Lamp decode from registered state only.
    always_comb begin
        w_lights = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            case (r_state)
                ST_GREEN: begin
                    if (r_phase == PH_W'(i)) w_lights[3*i+LAMP_G] = 1'b1;
                    else                     w_lights[3*i+LAMP_R] = 1'b1;
                end
                ST_YELLOW: begin
                    if (r_phase == PH_W'(i)) w_lights[3*i+LAMP_Y] = 1'b1;
                    else                     w_lights[3*i+LAMP_R] = 1'b1;
                end
                ST_FLASH: begin
                    w_lights[3*i+LAMP_Y] = r_flash_on;
                end
                default: begin
                    w_lights[3*i+LAMP_R] = 1'b1;
                end
            endcase
        end
    end

    assign lights      = w_lights;
    assign phase       = r_phase;
    assign time_left   = (r_state == ST_FLASH) ? '0 : w_cnt;
    assign cycle_start = r_cycle_start;

endmodule
